// File: rtl/lpn_pkg.sv
// ============================================================================
// Module : lpn_pkg
// Brief  : Shared types, default sizes and width helpers for the LPN row selector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lpn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } rowsel_state_t;

    localparam int DEF_DATA_W    = 128;
    localparam int DEF_ROW_BEATS = 4;
    localparam int DEF_N_ROWS    = 450;
    localparam int DEF_K_ROWS    = 128;

    // Counter width that never collapses to zero bits for tiny configurations.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ROW_CNT_W  = cnt_w(DEF_N_ROWS);
    localparam int SEL_CNT_W  = cnt_w(DEF_K_ROWS + 1);
    localparam int BEAT_CNT_W = cnt_w(DEF_ROW_BEATS);

endpackage

`default_nettype wire

// File: rtl/lpn_axis_skid.sv
// ============================================================================
// Module : lpn_axis_skid
// Brief  : Two-entry AXI-Stream skid buffer; in_ready is a pure register output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lpn_axis_skid #(
    parameter int WIDTH = 138
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (out_ready || !r_out_valid) begin
            // Output slot frees up: refill from the skid entry first to keep order.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= in_valid;
                r_out_data  <= in_data;
            end
        end else if (in_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign empty     = !r_out_valid && !r_skid_valid;

endmodule

`default_nettype wire

// File: rtl/lpn_row_selector.sv
// ============================================================================
// Module : lpn_row_selector
// Brief  : AXI-Stream row filter forwarding the first K_ROWS selected matrix rows.
//          Define LPN_ROWSEL_SKID_EN to register the output path through a skid buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lpn_row_selector
    import lpn_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ROW_BEATS = 4,
    parameter int N_ROWS    = 450,
    parameter int K_ROWS    = 128
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [N_ROWS-1:0]         sel_vec,
    input  logic [DATA_W-1:0]         s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic                      s_tlast,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic [$clog2(N_ROWS)-1:0] row_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      fault
);

    localparam int c_ROW_W  = $clog2(N_ROWS);
    localparam int c_SEL_W  = cnt_w(K_ROWS + 1);
    localparam int c_BEAT_W = cnt_w(ROW_BEATS);
    localparam int c_SKID_W = DATA_W + c_ROW_W + 1;

    rowsel_state_t       r_state;
    rowsel_state_t       w_state_next;
    logic [N_ROWS-1:0]   r_sel_vec;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic [c_ROW_W-1:0]  r_row_cnt;
    logic [c_SEL_W-1:0]  r_sel_cnt;
    logic                r_fault;

    logic                w_run;
    logic                w_start_ok;
    logic                w_last_beat;
    logic                w_last_row;
    logic                w_fwd_row;
    logic                w_frame_err;
    logic                w_fwd_ready;
    logic                w_accept;
    logic                w_row_end;
    logic                w_pass_end;
    logic                w_sel_inc;
    logic                w_short_sel;
    logic                w_drained;
    logic                w_fwd_valid;
    logic [DATA_W-1:0]   w_fwd_data;
    logic [c_ROW_W-1:0]  w_fwd_row_idx;
    logic                w_fwd_last;

    assign w_run       = (r_state == RUN);
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == FAULT));
    assign w_last_beat = (r_beat_cnt == c_BEAT_W'(ROW_BEATS - 1));
    assign w_last_row  = (r_row_cnt == c_ROW_W'(N_ROWS - 1));
    // Decision is stable for a whole row because sel_cnt only moves at row end.
    assign w_fwd_row   = r_sel_vec[r_row_cnt] && (r_sel_cnt < c_SEL_W'(K_ROWS));
    assign w_frame_err = w_run && s_tvalid && (s_tlast != w_last_beat);

    // A mis-framed beat is swallowed so the fault is taken regardless of m_tready.
    always_comb begin
        s_tready = 1'b0;
        if (w_run) begin
            if (w_frame_err || !w_fwd_row) begin
                s_tready = 1'b1;
            end else begin
                s_tready = w_fwd_ready;
            end
        end
    end

    assign w_accept    = s_tvalid && s_tready && !w_frame_err;
    assign w_row_end   = w_accept && w_last_beat;
    assign w_pass_end  = w_row_end && w_last_row;
    assign w_sel_inc   = w_row_end && w_fwd_row;
    assign w_short_sel = (r_sel_cnt + c_SEL_W'(w_sel_inc)) < c_SEL_W'(K_ROWS);

    assign w_fwd_valid   = w_run && w_fwd_row && s_tvalid && !w_frame_err;
    assign w_fwd_data    = w_fwd_valid ? s_tdata : '0;
    assign w_fwd_row_idx = w_fwd_valid ? r_row_cnt : '0;
    assign w_fwd_last    = w_fwd_valid && w_last_beat;

`ifdef LPN_ROWSEL_SKID_EN
    logic                w_skid_in_ready;
    logic                w_skid_empty;
    logic [c_SKID_W-1:0] w_skid_out;

    lpn_axis_skid #(
        .WIDTH (c_SKID_W)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (w_fwd_valid),
        .in_ready  (w_skid_in_ready),
        .in_data   ({w_fwd_data, w_fwd_row_idx, w_fwd_last}),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_data  (w_skid_out),
        .empty     (w_skid_empty)
    );

    assign {m_tdata, row_idx, m_tlast} = w_skid_out;
    assign w_fwd_ready = w_skid_in_ready;
    assign w_drained   = w_skid_empty;
`else
    assign m_tvalid    = w_fwd_valid;
    assign m_tdata     = w_fwd_data;
    assign row_idx     = w_fwd_row_idx;
    assign m_tlast     = w_fwd_last;
    assign w_fwd_ready = m_tready;
    assign w_drained   = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN: begin
                if (w_frame_err) begin
                    w_state_next = FAULT;
                end else if (w_pass_end) begin
                    w_state_next = DONE;
                end
            end
            DONE:    if (w_drained) w_state_next = IDLE;
            FAULT:   if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = w_run;
        done  = (r_state == DONE) && w_drained;
        fault = r_fault;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel_vec  <= '0;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
            r_sel_cnt  <= '0;
            r_fault    <= 1'b0;
        end else if (w_start_ok) begin
            r_sel_vec  <= sel_vec;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
            r_sel_cnt  <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                if (w_last_beat) begin
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
                if (w_sel_inc) begin
                    r_sel_cnt <= r_sel_cnt + 1'b1;
                end
            end
            if (w_frame_err || (w_pass_end && w_short_sel)) begin
                r_fault <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
